// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash read controller.
package spi_flash_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_ADDR_W    = 24;
    localparam int         SPI_XFER_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // Bytes arrive B0 first, so the shifted word holds {B0,B1,B2,B3}.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock divider: sck idles low, toggles every CLK_DIV cycles while enabled.
module spi_sck_gen
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       wrap;

    // Strobes mark the clock edge at which sck changes, so the consumer acts on that same edge.
    assign wrap = en && (cnt == 8'(CLK_DIV - 1));
    assign rise = wrap && !sck;
    assign fall = wrap && sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// Wishbone read-only front end that turns each read into one SPI READ (0x03) of 32 bits.
module spi_flash_rd_ctrl
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [23:0] wbs_adr_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        spi_sck,
    output logic        spi_csb,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    state_t                   state_q, state_d;
    logic [SPI_XFER_BITS-1:0] tx;
    logic [31:0]              rx;
    logic [5:0]               bit_cnt;
    logic [15:0]              gap_cnt;
    logic                     aborted, ack_pend;
    logic                     sck_rise, sck_fall, last_fall, req, sck_en;
    logic                     unused_in;

    assign unused_in = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // A pending ack/err blocks re-sampling so a lingering strobe cannot start a second access.
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign last_fall = sck_fall && (bit_cnt == 6'(SPI_XFER_BITS - 1));
    assign sck_en    = (state_q == SHIFT);
    assign spi_mosi  = tx[SPI_XFER_BITS-1];
    assign busy      = (state_q != IDLE);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .en  (sck_en),
        .sck (spi_sck),
        .rise(sck_rise),
        .fall(sck_fall)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = wbs_we_i ? GAP : SHIFT;
            SHIFT:   if (last_fall) state_d = GAP;
            GAP:     if (gap_cnt == 16'(CS_GAP - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            aborted   <= 1'b0;
            ack_pend  <= 1'b0;
            spi_csb   <= 1'b1;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            gap_cnt   <= (state_q == GAP) ? gap_cnt + 16'd1 : '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (wbs_we_i) begin
                            wbs_err_o <= 1'b1;
                        end else begin
                            tx      <= {SPI_CMD_READ, wbs_adr_i[23:2], 2'b00, 32'h0};
                            spi_csb <= 1'b0;
                            bit_cnt <= '0;
                            aborted <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    // The frame always runs to completion; a dropped cycle only kills the ack.
                    if (!wbs_cyc_i) aborted <= 1'b1;
                    if (sck_rise && bit_cnt[5]) rx <= {rx[30:0], spi_miso};
                    if (sck_fall) begin
                        tx      <= {tx[SPI_XFER_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (last_fall) begin
                        spi_csb   <= 1'b1;
                        wbs_dat_o <= bswap32(rx);
                        ack_pend  <= ~aborted & wbs_cyc_i;
                    end
                end
                GAP: begin
                    wbs_ack_o <= ack_pend;
                    ack_pend  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench: three controllers (CLK_DIV 1/2/4) against a behavioural flash and a cycle-level model.
module tb_spi_flash_rd_ctrl;

    localparam int N      = 3;
    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc [N];
    logic        stb [N];
    logic        we  [N];
    logic [3:0]  sel [N];
    logic [23:0] adr [N];
    logic [31:0] dat [N];
    logic        ack [N];
    logic        err [N];
    logic        sck [N];
    logic        csb [N];
    logic        mosi[N];
    logic        busy[N];

    logic [7:0]  mem [4096];
    int          cyc_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Model state, owned by the compare process.
    int          m_busy_until[N];
    int          m_ack_at[N];
    int          m_err_at[N];
    int          m_start[N];
    logic [23:0] m_adr[N];
    logic [31:0] m_dat[N];
    logic [31:0] m_dat_next[N];
    int          m_dat_at[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, g, cyc_cnt, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic        so = 1'b0;
        int          rises = 0;
        int          last_rises = 0;
        logic [31:0] ca = '0;
        logic [31:0] last_ca = '0;

        spi_flash_rd_ctrl #(.CLK_DIV((g == 0) ? 1 : (g == 1) ? 2 : 4), .CS_GAP(CS_GAP)) u_dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .wbs_cyc_i(cyc[g]),
            .wbs_stb_i(stb[g]),
            .wbs_we_i (we[g]),
            .wbs_sel_i(sel[g]),
            .wbs_adr_i(adr[g]),
            .wbs_dat_o(dat[g]),
            .wbs_ack_o(ack[g]),
            .wbs_err_o(err[g]),
            .spi_sck  (sck[g]),
            .spi_csb  (csb[g]),
            .spi_mosi (mosi[g]),
            .spi_miso (so),
            .busy     (busy[g])
        );

        // Flash: takes 32 command/address bits on rising sck, answers on falling sck.
        always @(posedge sck[g] or posedge csb[g]) begin
            if (csb[g]) begin
                last_rises = rises;
                last_ca    = ca;
                rises      = 0;
            end else begin
                if (rises < 32) ca = {ca[30:0], mosi[g]};
                rises++;
            end
        end

        always @(negedge sck[g]) begin
            int k;
            logic [7:0] by;
            if (!csb[g] && rises >= 32 && rises < 64) begin
                k  = rises - 32;
                by = mem[12'(ca[11:0] + 12'(k / 8))];
                so = by[7 - (k % 8)];
            end
        end
    end

    // Cycle-level expectations derived from request time, CLK_DIV and CS_GAP.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            int d, j, bi;
            logic e_csb, e_sck, e_mosi, e_ack, e_err, e_busy, in_x;
            logic [31:0] w;
            d = div_of(g);
            if (rst) begin
                chk("rst_csb", g, 32'(csb[g]), 32'd1);
                chk("rst_sck", g, 32'(sck[g]), 32'd0);
                chk("rst_mosi", g, 32'(mosi[g]), 32'd0);
                chk("rst_ack", g, 32'(ack[g]), 32'd0);
                chk("rst_err", g, 32'(err[g]), 32'd0);
                chk("rst_dat", g, dat[g], 32'd0);
                chk("rst_busy", g, 32'(busy[g]), 32'd0);
                m_busy_until[g] = -1;
                m_ack_at[g]     = -1;
                m_err_at[g]     = -1;
                m_start[g]      = -1;
                m_dat[g]        = '0;
                m_dat_at[g]     = -1;
            end else begin
                if (m_dat_at[g] == cyc_cnt) m_dat[g] = m_dat_next[g];
                j    = cyc_cnt - m_start[g];
                in_x = (m_start[g] >= 0) && (j >= 1) && (j <= 128 * d);
                if (in_x && !cyc[g]) m_ack_at[g] = -1;
                e_csb  = !in_x;
                e_sck  = in_x ? (((j - 1) / d) % 2 == 1) : 1'b0;
                e_mosi = 1'b0;
                if (in_x) begin
                    bi = (j - 1) / (2 * d);
                    w  = {8'h03, m_adr[g][23:2], 2'b00};
                    if (bi < 32) e_mosi = w[31 - bi];
                end
                e_ack  = (cyc_cnt == m_ack_at[g]);
                e_err  = (cyc_cnt == m_err_at[g]);
                e_busy = (cyc_cnt <= m_busy_until[g]);
                chk("csb", g, 32'(csb[g]), 32'(e_csb));
                chk("sck", g, 32'(sck[g]), 32'(e_sck));
                chk("mosi", g, 32'(mosi[g]), 32'(e_mosi));
                chk("ack", g, 32'(ack[g]), 32'(e_ack));
                chk("err", g, 32'(err[g]), 32'(e_err));
                chk("busy", g, 32'(busy[g]), 32'(e_busy));
                chk("dat", g, dat[g], m_dat[g]);
                if (cyc_cnt > m_busy_until[g] && cyc[g] && stb[g] && !e_ack && !e_err) begin
                    if (we[g]) begin
                        m_err_at[g]     = cyc_cnt + 1;
                        m_busy_until[g] = cyc_cnt + CS_GAP;
                    end else begin
                        m_start[g]      = cyc_cnt;
                        m_adr[g]        = adr[g];
                        m_ack_at[g]     = cyc_cnt + 128 * d + 2;
                        m_busy_until[g] = cyc_cnt + 128 * d + CS_GAP;
                        m_dat_next[g]   = flash_word(adr[g]);
                        m_dat_at[g]     = cyc_cnt + 128 * d + 1;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int g);
        for (int n = 0; n < 2000; n++) begin
            if (!busy[g]) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", g, 32'(busy[g]), 32'd0);
    endtask

    task automatic do_read(input int g, input logic [23:0] a, input int abort_bit,
                           output int lat, output logic [31:0] d, output bit acked);
        int t0;
        wait_idle(g);
        @(posedge clk); #1;
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = 1'b0; adr[g] = a; sel[g] = 4'($urandom);
        t0 = cyc_cnt; acked = 1'b0; lat = -1; d = '0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            if (ack[g]) begin
                acked = 1'b1; lat = cyc_cnt - t0; d = dat[g];
                @(posedge clk); #1;
                break;
            end
            if (abort_bit >= 0 && cyc_cnt - t0 == 1 + abort_bit * 2 * div_of(g)) begin
                cyc[g] = 1'b0; stb[g] = 1'b0;
            end
            if (!cyc[g] && !busy[g]) break;
        end
        cyc[g] = 1'b0; stb[g] = 1'b0;
        if (abort_bit < 0) chk("ack_seen", g, 32'(acked), 32'd1);
    endtask

    task automatic do_write(input int g);
        int errs, acks, first;
        wait_idle(g);
        @(posedge clk); #1;
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = 1'b1; adr[g] = 24'($urandom);
        errs = 0; acks = 0; first = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0; end
            if (err[g]) begin errs++; if (first < 0) first = n; end
            if (ack[g]) acks++;
        end
        chk("wr_err_count", g, 32'(errs), 32'd1);
        chk("wr_err_cycle", g, 32'(first), 32'd1);
        chk("wr_no_ack", g, 32'(acks), 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] d;
        bit acked;
        logic [23:0] a;
        int g;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        mem[0]  = 8'h6F; mem[1]  = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h13;
        for (int i = 0; i < N; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'hF; adr[i] = '0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // CLK_DIV=2 reference read.
        do_read(1, 24'h000012, -1, lat, d, acked);
        chk("d2_dat", 1, d, 32'h44332211);
        chk("d2_latency", 1, 32'(lat), 32'd258);
        chk("d2_rises", 1, 32'(g_dut[1].last_rises), 32'd64);
        chk("d2_cmd_addr", 1, g_dut[1].last_ca, 32'h03000010);

        do_read(0, 24'h000000, -1, lat, d, acked);
        chk("d1_dat", 0, d, 32'h1300006F);
        chk("d1_latency", 0, 32'(lat), 32'd130);
        do_read(2, 24'h000000, -1, lat, d, acked);
        chk("d4_dat", 2, d, 32'h1300006F);
        chk("d4_latency", 2, 32'(lat), 32'd514);
        chk("d4_rises", 2, 32'(g_dut[2].last_rises), 32'd64);

        do_write(1);

        // Back-to-back reads; the compare process polices the chip-select gap.
        do_read(1, 24'h000010, -1, lat, d, acked);
        chk("b2b_dat0", 1, d, 32'h44332211);
        do_read(1, 24'h000014, -1, lat, d, acked);
        chk("b2b_dat1", 1, d, {mem[23], mem[22], mem[21], mem[20]});

        // Abort at bit 20: frame completes, no ack, then a normal read.
        do_read(1, 24'h000010, 20, lat, d, acked);
        chk("abort_no_ack", 1, 32'(acked), 32'd0);
        chk("abort_rises", 1, 32'(g_dut[1].last_rises), 32'd64);
        chk("abort_dat_kept", 1, dat[1], 32'h44332211);
        do_read(1, 24'h000014, -1, lat, d, acked);
        chk("post_abort_dat", 1, d, {mem[23], mem[22], mem[21], mem[20]});

        // Reset in the middle of bit 30.
        wait_idle(1);
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 24'h000010;
        repeat (1 + 30 * 4) @(posedge clk);
        #1 chk("pre_rst_csb", 1, 32'(csb[1]), 32'd0);
        #2 rst = 1'b1;
        #1 chk("mid_rst_csb", 1, 32'(csb[1]), 32'd1);
        chk("mid_rst_sck", 1, 32'(sck[1]), 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        do_read(1, 24'h000010, -1, lat, d, acked);
        chk("post_rst_dat", 1, d, 32'h44332211);

        // Top-of-flash address.
        do_read(0, 24'hFFFFFE, -1, lat, d, acked);
        chk("wrap_dat", 0, d, {mem[4095], mem[4094], mem[4093], mem[4092]});
        chk("wrap_cmd_addr", 0, g_dut[0].last_ca, 32'h03FFFFFC);

        for (int it = 0; it < 15; it++) begin
            g = int'($urandom_range(0, N - 1));
            a = 24'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                do_write(g);
            end else begin
                do_read(g, a, -1, lat, d, acked);
                chk("rnd_dat", g, d, flash_word(a));
                chk("rnd_latency", g, 32'(lat), 32'(128 * div_of(g) + 2));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int i = 0; i < N; i++) wait_idle(i);
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_rd_ctrl.md
Name: spi_flash_rd_ctrl

Overview:
Wishbone-slave, read-only SPI flash controller. It is the initiator side of the single-bit SPI flash read protocol that the chip-level flash model answers. Each Wishbone read becomes one SPI READ (0x03) transaction that returns a 32-bit little-endian word. It sits between the user-project Wishbone interconnect and the pinmux flash pads, so user logic can fetch constants and code directly from flash.

Parameters:
CLK_DIV, 2, SCK half-period in wb_clk_i cycles; legal range 1..255.
CS_GAP, 2, minimum wb_clk_i cycles that spi_csb stays high between transactions; must be >=1.

Ports:
wb_clk_i  in  1  system clock; the only clock.
wb_rst_i  in  1  asynchronous, active-high reset.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  write enable; writes are not supported.
wbs_sel_i  in  4  byte select; ignored, a full word is always returned.
wbs_adr_i  in  24  byte address; bits [1:0] are ignored.
wbs_dat_o  out  32  read data.
wbs_ack_o  out  1  single-cycle acknowledge.
wbs_err_o  out  1  single-cycle error (write attempt).
spi_sck  out  1  SPI clock, mode 0.
spi_csb  out  1  chip select, active low.
spi_mosi  out  1  serial command/address out.
spi_miso  in  1  serial data in.
busy  out  1  high while a SPI transaction or the CS gap is in progress.

Behaviour:
- Reset (async, any time): spi_csb=1, spi_sck=0, spi_mosi=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, busy=0, state=IDLE.
- A request is cyc&stb sampled in IDLE.
- Read request:
  - Latch tx shift register = {8'h03, adr[23:2], 2'b00, 32'h0}.
  - Next cycle: spi_csb=0, state=SHIFT, bit counter=0, spi_mosi=tx[63].
- SHIFT:
  - SCK toggles every CLK_DIV cycles, starting low; 64 full SCK periods in total.
  - MISO is sampled on each rising SCK edge.
  - MOSI and the counter advance on each falling edge. MOSI is meaningful only for bits 0..31; it is driven 0 during bits 32..63.
  - Received bytes B0..B3 (B0 = flash[A]) are assembled as dat = {B3,B2,B1,B0}; each byte arrives MSB first.
- Falling edge after bit 63: spi_csb=1, spi_sck=0, wbs_dat_o updated, wbs_ack_o=1 for exactly one cycle, state=GAP.
  - Request-to-ack latency is exactly 128*CLK_DIV+2 cycles (request sampled cycle = 0).
- Write request (we=1) in IDLE: wbs_err_o=1 for one cycle on the next cycle, no SPI activity, state=GAP.
- GAP: hold spi_csb high for CS_GAP cycles, then go to IDLE.
  - A strobe still asserted during GAP is not treated as a new request, so a request is never double-acked.
- Abort: if cyc drops during SHIFT, the SPI transaction still completes (flash framing is preserved), but ack is suppressed and wbs_dat_o is still updated.
- wbs_ack_o and wbs_err_o are never high together.
- busy = (state != IDLE).
- Address wrap: 0xFFFFFC reads bytes FC..FF; the flash handles wrap internally, and the controller does no address arithmetic.

Decomposition:
- Package spi_flash_pkg:
  - SPI_CMD_READ=8'h03.
  - Constants SPI_ADDR_W=24 and SPI_XFER_BITS=64.
  - State encoding IDLE/SHIFT/GAP.
- Sub-module spi_sck_gen:
  - CLK_DIV counter generating spi_sck plus one-cycle rise/fall strobes.
  - Enable input, synchronous clear on enable low.
- The FSM and shift registers live in the top module.

Test Plan:
- Flash model preloaded with 0x11,0x22,0x33,0x44 at 0x000010; read adr=0x000012, CLK_DIV=2 -> MOSI bits = 0x03,0x000010; wbs_dat_o=0x44332211; ack at cycle 258; exactly 64 SCK rising edges.
- CLK_DIV=1: read 0x000000 (bytes 0x6F,0x00,0x00,0x13) -> dat=0x1300006F, ack at cycle 130; CLK_DIV=4 -> ack at cycle 514.
- Write with stb held -> wbs_err_o pulses once the cycle after the request; spi_csb stays 1; no ack.
- Two back-to-back reads (0x10, 0x14) -> spi_csb high for >=CS_GAP cycles between them; two distinct acks with correct data.
- Drop cyc at bit 20 -> no ack; transaction still runs 64 bits; next read returns correct data.
- Assert wb_rst_i at bit 30 -> same cycle spi_csb=1 and spi_sck=0; after release, a new read succeeds.
